// File: rtl/ex_mem_skid_reg.sv
// ex_mem_skid_reg
//   Execute->memory pipeline register placed directly after the 64-bit ALU.
//   Captures the ALU result, zero flag, store data, destination register and
//   memory/writeback control. A valid/ready handshake backed by a 2-entry skid
//   buffer (main + skid) lets the memory stage stall. in_ready comes from a
//   register, so there is no combinational path from out_ready back into
//   execute.
//
//   Optional feature macro: EXMEM_BRANCH_RESOLVE_EN
//     defined   : branch_taken = in_branch & in_zero is stored per entry and
//                 presented as out_branch_taken (gated by out_valid)
//     undefined : out_branch_taken is tied to 0 and nothing extra is stored
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   flush               synchronous pipeline kill (branch redirect)
//   in_valid/in_ready   upstream handshake
//   in_*                execute-stage payload
//   out_valid/out_ready downstream handshake
//   out_*               registered payload; mem_read/mem_write/reg_write and
//                       branch_taken are forced low while out_valid is low
module ex_mem_skid_reg #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic              in_zero,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic              in_reg_write,
    input  logic              in_mem_to_reg,
    input  logic              in_branch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_alu_result,
    output logic              out_zero,
    output logic [DATA_W-1:0] out_store_data,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_reg_write,
    output logic              out_mem_to_reg,
    output logic              out_branch_taken
);

    typedef struct packed {
        logic [DATA_W-1:0] alu_result;
        logic              zero;
        logic [DATA_W-1:0] store_data;
        logic [RD_W-1:0]   rd;
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
        logic              mem_to_reg;
`ifdef EXMEM_BRANCH_RESOLVE_EN
        logic              branch_taken;
`endif
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    entry_t main_q;
    entry_t skid_q;
    entry_t in_entry;
    logic   rdy_q;
    logic   in_xfer;
    logic   out_xfer;

    always_comb begin
        in_entry            = '0;
        in_entry.alu_result = in_alu_result;
        in_entry.zero       = in_zero;
        in_entry.store_data = in_store_data;
        in_entry.rd         = in_rd;
        in_entry.mem_read   = in_mem_read;
        in_entry.mem_write  = in_mem_write;
        in_entry.reg_write  = in_reg_write;
        in_entry.mem_to_reg = in_mem_to_reg;
`ifdef EXMEM_BRANCH_RESOLVE_EN
        in_entry.branch_taken = in_branch & in_zero;
`endif
    end

    // rdy_q mirrors (state != FULL) for the next cycle; only rst is combined
    // in directly so in_ready drops while reset is held.
    assign in_ready  = rdy_q & ~rst;
    assign out_valid = (state != EMPTY);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
            rdy_q  <= 1'b1;
        end else if (flush) begin
            // Payload registers keep their contents; control outputs are
            // gated off by out_valid, so nothing stale can write.
            state <= EMPTY;
            rdy_q <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        main_q <= in_entry;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_q <= in_entry;
                    end else if (in_xfer) begin
                        skid_q <= in_entry;
                        state  <= FULL;
                        rdy_q  <= 1'b0;
                    end else if (out_xfer) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        main_q <= skid_q;
                        state  <= ONE;
                        rdy_q  <= 1'b1;
                    end
                end
                default: begin
                    state <= EMPTY;
                    rdy_q <= 1'b1;
                end
            endcase
        end
    end

    assign out_alu_result = main_q.alu_result;
    assign out_zero       = main_q.zero;
    assign out_store_data = main_q.store_data;
    assign out_rd         = main_q.rd;
    assign out_mem_to_reg = main_q.mem_to_reg;
    assign out_mem_read   = main_q.mem_read  & out_valid;
    assign out_mem_write  = main_q.mem_write & out_valid;
    assign out_reg_write  = main_q.reg_write & out_valid;

`ifdef EXMEM_BRANCH_RESOLVE_EN
    assign out_branch_taken = main_q.branch_taken & out_valid;
`else
    logic unused_branch;
    assign unused_branch    = in_branch;
    assign out_branch_taken = 1'b0;
`endif

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// tb_ex_mem_skid_reg
//   Directed bench for ex_mem_skid_reg. Stimulus pushes the expected payload
//   into a queue whenever an input transfer is issued; an independent monitor
//   on the falling edge compares the presented output against the queue head
//   and pops it when the output is consumed.
module tb_ex_mem_skid_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_alu_result;
    logic        in_zero;
    logic [63:0] in_store_data;
    logic [4:0]  in_rd;
    logic        in_mem_read;
    logic        in_mem_write;
    logic        in_reg_write;
    logic        in_mem_to_reg;
    logic        in_branch;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_alu_result;
    logic        out_zero;
    logic [63:0] out_store_data;
    logic [4:0]  out_rd;
    logic        out_mem_read;
    logic        out_mem_write;
    logic        out_reg_write;
    logic        out_mem_to_reg;
    logic        out_branch_taken;

    ex_mem_skid_reg #(.DATA_W(64), .RD_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_result(in_alu_result), .in_zero(in_zero),
        .in_store_data(in_store_data), .in_rd(in_rd),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
        .in_branch(in_branch),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_result(out_alu_result), .out_zero(out_zero),
        .out_store_data(out_store_data), .out_rd(out_rd),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_reg_write(out_reg_write), .out_mem_to_reg(out_mem_to_reg),
        .out_branch_taken(out_branch_taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] alu;
        logic [63:0] sd;
        logic [4:0]  rd;
        logic        mr;
        logic        mw;
        logic        rw;
        logic        m2r;
        logic        zero;
        logic        br;
    } pl_t;

    pl_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    bit  mon_en   = 1'b0;

    task automatic check1(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic pl_t mk(input logic [63:0] alu, input logic [63:0] sd, input logic [4:0] rd,
                               input logic mr, input logic mw, input logic rw, input logic m2r,
                               input logic zero, input logic br);
        pl_t p;
        p.alu = alu; p.sd = sd; p.rd = rd; p.mr = mr; p.mw = mw;
        p.rw = rw; p.m2r = m2r; p.zero = zero; p.br = br;
        return p;
    endfunction

    function automatic logic exp_taken(input pl_t p);
`ifdef EXMEM_BRANCH_RESOLVE_EN
        return p.br & p.zero;
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive(input pl_t p);
        in_alu_result = p.alu; in_store_data = p.sd; in_rd = p.rd;
        in_mem_read = p.mr; in_mem_write = p.mw; in_reg_write = p.rw;
        in_mem_to_reg = p.m2r; in_zero = p.zero; in_branch = p.br;
    endtask

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    // waits reports how many cycles in_ready was low.
    task automatic send(input pl_t p, output int waits);
        waits = 0;
        drive(p);
        in_valid = 1'b1;
        while (!in_ready && waits <= 100) begin
            @(posedge clk); #1;
            waits++;
        end
        if (!in_ready) begin
            check1("send_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(p);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queue head.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got alu=%0h with no expected entry at %0t",
                             out_alu_result, $time);
                end else begin
                    check1("out_alu_result", out_alu_result, exp_q[0].alu);
                    check1("out_store_data", out_store_data, exp_q[0].sd);
                    check1("out_rd",         64'(out_rd),         64'(exp_q[0].rd));
                    check1("out_zero",       64'(out_zero),       64'(exp_q[0].zero));
                    check1("out_mem_read",   64'(out_mem_read),   64'(exp_q[0].mr));
                    check1("out_mem_write",  64'(out_mem_write),  64'(exp_q[0].mw));
                    check1("out_reg_write",  64'(out_reg_write),  64'(exp_q[0].rw));
                    check1("out_mem_to_reg", 64'(out_mem_to_reg), 64'(exp_q[0].m2r));
                    check1("out_branch_taken", 64'(out_branch_taken), 64'(exp_taken(exp_q[0])));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end else begin
                check1("idle_ctrl_gated",
                       64'({out_mem_read, out_mem_write, out_reg_write, out_branch_taken}), 64'd0);
            end
        end
    end

    initial begin
        int w;
        int total;
        pl_t a, b;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(mk(64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

        // Reset: two cycles, everything low
        cycles(2);
        @(negedge clk);
        check1("rst_out_valid", 64'(out_valid), 64'd0);
        check1("rst_in_ready",  64'(in_ready),  64'd0);
        check1("rst_out_data",  out_alu_result | out_store_data, 64'd0);
        check1("rst_out_ctrl",  64'({out_zero, out_rd, out_mem_read, out_mem_write,
                                     out_reg_write, out_mem_to_reg, out_branch_taken}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check1("post_rst_in_ready", 64'(in_ready), 64'd1);
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Latency: one cycle from input transfer to out_valid
        out_ready = 1'b1;
        send(mk(64'h5, 64'h0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), w);
        check1("latency_out_valid", 64'(out_valid), 64'd1);
        check1("latency_out_alu",   out_alu_result, 64'h5);
        cycles(2);

        // Stall / skid: A then B while stalled, then drain
        out_ready = 1'b0;
        a = mk(64'h10, 64'hAAAA, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        b = mk(64'h20, 64'hBBBB, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        send(a, w);
        send(b, w);
        check1("full_in_ready", 64'(in_ready), 64'd0);
        cycles(3);
        check1("stall_out_alu", out_alu_result, 64'h10);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check1("after_A_in_ready",  64'(in_ready),  64'd1);
        check1("after_A_out_alu",   out_alu_result, 64'h20);
        @(posedge clk); #1;
        check1("after_B_out_valid", 64'(out_valid), 64'd0);

        // Streaming: 8 back-to-back with out_ready high, no wait cycles
        total = 0;
        for (int i = 1; i <= 8; i++) begin
            send(mk(64'(i), 64'(i) << 8, 5'(i), 1'(i % 2), 1'(i / 4 % 2), 1'b1, 1'(i % 2),
                    1'(i % 3 == 0), 1'b0), w);
            total += w;
        end
        check1("stream_wait_cycles", 64'(total), 64'd0);
        cycles(2);
        check1("stream_drained", 64'(exp_q.size()), 64'd0);

        // Branch resolve
        send(mk(64'h0, 64'h1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), w);
        send(mk(64'h3, 64'h2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), w);
        send(mk(64'h0, 64'h3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), w);
        cycles(2);

        // Flush from FULL with store payloads, plus a blocked input
        out_ready = 1'b0;
        send(mk(64'h100, 64'hDEAD, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), w);
        send(mk(64'h200, 64'hBEEF, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), w);
        drive(mk(64'h300, 64'hF00D, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        check1("flush_out_valid",     64'(out_valid),     64'd0);
        check1("flush_out_mem_write", 64'(out_mem_write), 64'd0);
        check1("flush_in_ready",      64'(in_ready),      64'd1);
        out_ready = 1'b1;
        cycles(3);

        // Flush from ONE with an accepted input that cycle: input dropped
        out_ready = 1'b0;
        send(mk(64'h400, 64'h4, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), w);
        drive(mk(64'h500, 64'h5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        check1("flush1_out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        cycles(3);

        // Reset mid-stall discards both entries
        out_ready = 1'b0;
        send(mk(64'h600, 64'h6, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0), w);
        send(mk(64'h700, 64'h7, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), w);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        check1("midrst_in_ready",  64'(in_ready),  64'd0);
        check1("midrst_out_valid", 64'(out_valid), 64'd0);
        check1("midrst_out_data",  out_alu_result | out_store_data, 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        cycles(3);

        check1("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
